// File: rtl/binary_clock_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : binary_clock_core
// Description : 12-hour timekeeping core. Divides the board clock down to a
//               1 Hz time base and keeps hours/minutes/seconds/AM-PM, with
//               button-driven setting of hours and minutes.
// Ports       : clk_100MHz  - system clock, rising edge
//               reset       - synchronous, active-low reset
//               inc_hour    - raw hour-set button (asynchronous)
//               inc_minute  - raw minute-set button (asynchronous)
//               tick_1Hz    - 1 Hz square wave (low first half, high second)
//               sec_pulse   - one-cycle strobe aligned with each new second
//               end_of_day  - high throughout 11:59:59 PM
//               hours/minutes/seconds/am_or_pm - binary time
//               h_10s..s_1s - BCD digits of the time
// Revision    : 1.0 - initial release
// ============================================================================
module binary_clock_core #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       inc_hour,
    input  logic       inc_minute,
    output logic       tick_1Hz,
    output logic       sec_pulse,
    output logic       end_of_day,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       am_or_pm,
    output logic [3:0] h_10s,
    output logic [3:0] h_1s,
    output logic [3:0] m_10s,
    output logic [3:0] m_1s,
    output logic [3:0] s_10s,
    output logic [3:0] s_1s
);

    localparam int                 c_CNT_W    = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(CLK_HZ - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLK_HZ / 2);

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_sec_carry;
    logic               r_tick;
    logic               r_sec_pulse;

    assign w_sec_carry = (r_cnt == c_CNT_MAX);
    assign w_cnt_next  = w_sec_carry ? '0 : r_cnt + 1'b1;

    // The tick is registered from the next count so it lines up with the
    // count it describes: low while cnt < CLK_HZ/2, high otherwise.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_tick      <= 1'b0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_tick      <= (w_cnt_next >= c_CNT_HALF);
            r_sec_pulse <= w_sec_carry;
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizers and edge detect. Bit 0 is the first sync flop.
    // The edge-detect output is registered, giving four edges from a
    // button change to the time update.
    // ------------------------------------------------------------------
    logic [2:0] r_hr_sync;
    logic [2:0] r_min_sync;
    logic       r_hr_evt;
    logic       r_min_evt;

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_hr_sync  <= '0;
            r_min_sync <= '0;
            r_hr_evt   <= 1'b0;
            r_min_evt  <= 1'b0;
        end else begin
            r_hr_sync  <= {r_hr_sync[1:0], inc_hour};
            r_min_sync <= {r_min_sync[1:0], inc_minute};
            r_hr_evt   <= r_hr_sync[1] & ~r_hr_sync[2];
            r_min_evt  <= r_min_sync[1] & ~r_min_sync[2];
        end
    end

    // ------------------------------------------------------------------
    // Time chain
    // ------------------------------------------------------------------
    logic [3:0] r_hours;
    logic [5:0] r_minutes;
    logic [5:0] r_seconds;
    logic       r_pm;
    logic       r_eod;

    logic [3:0] w_hours_next;
    logic [5:0] w_minutes_next;
    logic [5:0] w_seconds_next;
    logic       w_pm_next;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic       w_hr_step;
    logic       w_eod_next;

    always_comb begin
        w_sec_wrap     = w_sec_carry && (r_seconds == 6'd59);
        // A minute button event owns the minutes field for that cycle, so
        // the rollover it may cause never carries into hours.
        w_min_wrap     = w_sec_wrap && (r_minutes == 6'd59) && !r_min_evt;
        // Hour button and minute carry together still advance hours once.
        w_hr_step      = r_hr_evt || w_min_wrap;

        w_seconds_next = r_seconds;
        w_minutes_next = r_minutes;
        w_hours_next   = r_hours;
        w_pm_next      = r_pm;

        if (r_min_evt) begin
            w_seconds_next = 6'd0;
        end else if (w_sec_carry) begin
            w_seconds_next = (r_seconds == 6'd59) ? 6'd0 : r_seconds + 6'd1;
        end

        if (r_min_evt || w_sec_wrap) begin
            w_minutes_next = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
        end

        if (w_hr_step) begin
            if (r_hours == 4'd12) begin
                w_hours_next = 4'd1;
            end else if (r_hours == 4'd11) begin
                w_hours_next = 4'd12;
                w_pm_next    = ~r_pm;
            end else begin
                w_hours_next = r_hours + 4'd1;
            end
        end

        w_eod_next = (w_hours_next == 4'd11) && (w_minutes_next == 6'd59) &&
                     (w_seconds_next == 6'd59) && w_pm_next;
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_hours   <= 4'd12;
            r_minutes <= 6'd0;
            r_seconds <= 6'd0;
            r_pm      <= 1'b0;
            r_eod     <= 1'b0;
        end else begin
            r_hours   <= w_hours_next;
            r_minutes <= w_minutes_next;
            r_seconds <= w_seconds_next;
            r_pm      <= w_pm_next;
            r_eod     <= w_eod_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tick_1Hz   = r_tick;
    assign sec_pulse  = r_sec_pulse;
    assign end_of_day = r_eod;
    assign hours      = r_hours;
    assign minutes    = r_minutes;
    assign seconds    = r_seconds;
    assign am_or_pm   = r_pm;

    assign h_10s = 4'(r_hours / 4'd10);
    assign h_1s  = 4'(r_hours % 4'd10);
    assign m_10s = 4'(r_minutes / 6'd10);
    assign m_1s  = 4'(r_minutes % 6'd10);
    assign s_10s = 4'(r_seconds / 6'd10);
    assign s_1s  = 4'(r_seconds % 6'd10);

endmodule
`default_nettype wire

// File: tb/tb_binary_clock_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_binary_clock_core
// Description : Self-checking bench for binary_clock_core. A time-of-day
//               reference model (seconds since midnight) is compared with
//               every DUT output on every cycle; directed sequences cover
//               the divider, rollovers, button latency and precedence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_clock_core;

    localparam int CLK_HZ = 4;
    localparam int DAY    = 86400;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b0;
    logic       inc_hour   = 1'b0;
    logic       inc_minute = 1'b0;
    logic       tick_1Hz, sec_pulse, end_of_day, am_or_pm;
    logic [3:0] hours, h_10s, h_1s, m_10s, m_1s, s_10s, s_1s;
    logic [5:0] minutes, seconds;

    int n_checks = 0;
    int n_errors = 0;

    binary_clock_core #(.CLK_HZ(CLK_HZ)) u_dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .inc_hour   (inc_hour),
        .inc_minute (inc_minute),
        .tick_1Hz   (tick_1Hz),
        .sec_pulse  (sec_pulse),
        .end_of_day (end_of_day),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .am_or_pm   (am_or_pm),
        .h_10s      (h_10s),
        .h_1s       (h_1s),
        .m_10s      (m_10s),
        .m_1s       (m_1s),
        .s_10s      (s_10s),
        .s_1s       (s_1s)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // ------------------------------------------------------------------
    // Reference model: time of day as seconds since midnight (0 = 12 AM),
    // phase within the current second, and the last four sampled values of
    // each button (bit 0 = most recent). A press sampled at edge k takes
    // effect at edge k+3.
    // ------------------------------------------------------------------
    int       m_t  = 0;
    int       m_ph = 0;
    bit       m_pulse = 1'b0;
    bit [3:0] m_hh = '0;
    bit [3:0] m_mh = '0;

    function automatic int model_next(int t, bit carry, bit hev, bit mev);
        int h, m, n;
        h = t / 3600;
        m = (t / 60) % 60;
        if (mev)        n = h * 3600 + ((m + 1) % 60) * 60;
        else if (carry) n = (t + 1) % DAY;
        else            n = t;
        if (hev && (n / 3600) == h) n = (n + 3600) % DAY;
        return n;
    endfunction

    always @(posedge clk_100MHz) begin
        if (!reset) begin
            m_t     <= 0;
            m_ph    <= 0;
            m_pulse <= 1'b0;
            m_hh    <= '0;
            m_mh    <= '0;
        end else begin
            m_t     <= model_next(m_t, m_ph == CLK_HZ - 1,
                                  m_hh[2] & ~m_hh[3], m_mh[2] & ~m_mh[3]);
            m_ph    <= (m_ph + 1) % CLK_HZ;
            m_pulse <= (m_ph == CLK_HZ - 1);
            m_hh    <= {m_hh[2:0], inc_hour};
            m_mh    <= {m_mh[2:0], inc_minute};
        end
    end

    function automatic logic [43:0] expected_vec();
        int h24, h12, mm, ss;
        h24 = m_t / 3600;
        h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
        mm  = (m_t / 60) % 60;
        ss  = m_t % 60;
        return {1'(m_ph >= CLK_HZ / 2), m_pulse, 1'(m_t == DAY - 1),
                4'(h12), 6'(mm), 6'(ss), 1'(h24 >= 12),
                4'(h12 / 10), 4'(h12 % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic check_model();
        logic [43:0] act, exp_v;
        act   = {tick_1Hz, sec_pulse, end_of_day, hours, minutes, seconds,
                 am_or_pm, h_10s, h_1s, m_10s, m_1s, s_10s, s_1s};
        exp_v = expected_vec();
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL model @%0t: got %h expected %h", $time, act, exp_v);
        end
    endtask

    task automatic check(string name, int act, int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // One clock, then compare everything on the falling edge.
    task automatic step();
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic press(bit hr, bit mn);
        inc_hour   = hr;
        inc_minute = mn;
        repeat (4) step();
        inc_hour   = 1'b0;
        inc_minute = 1'b0;
        repeat (4) step();
    endtask

    task automatic wait_for(int target, int ph, int budget, string name);
        int n;
        n = 0;
        while (!(m_t == target && m_ph == ph) && n < budget) begin
            step();
            n++;
        end
        check(name, int'(m_t == target && m_ph == ph), 1);
    endtask

    typedef struct {
        bit hr;
        bit mn;
        int exp_h;
        int exp_m;
        bit exp_pm;
    } vec_t;

    vec_t tbl [15];
    int   pat [4];

    initial begin
        int pulses, eod_cnt, eod_tick, changes, first_pulse, prev_min;

        tbl = '{'{1, 0, 12, 0, 1}, '{1, 0,  1, 0, 1}, '{1, 0,  2, 0, 1},
                '{1, 0,  3, 0, 1}, '{1, 0,  4, 0, 1}, '{1, 0,  5, 0, 1},
                '{1, 0,  6, 0, 1}, '{1, 0,  7, 0, 1}, '{1, 0,  8, 0, 1},
                '{1, 0,  9, 0, 1}, '{1, 0, 10, 0, 1}, '{1, 0, 11, 0, 1},
                '{1, 0, 12, 0, 0}, '{1, 1,  1, 1, 0}, '{0, 1,  1, 2, 0}};
        pat = '{0, 0, 1, 1};

        // ---- 1: reset and divider ------------------------------------
        reset = 1'b0;
        step();
        check("t1_reset_hours", hours, 12);
        check("t1_reset_tick", tick_1Hz, 0);
        reset  = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t1_tick", tick_1Hz, pat[k % 4]);
            pulses += sec_pulse;
            if (k == 3) check("t1_sec_c3", seconds, 0);
            if (k == 4) check("t1_sec_c4", seconds, 1);
            if (k == 4) check("t1_pulse_c4", sec_pulse, 1);
            if (k == 8) check("t1_sec_c8", seconds, 2);
        end
        check("t1_pulse_count", pulses, 2);
        check("t1_bcd", {h_10s, h_1s, m_10s, m_1s, s_10s, s_1s}, 24'h120002);

        // ---- 2: end of day -------------------------------------------
        do_reset();
        repeat (23) press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        wait_for(DAY - 2, 0, 400, "t2_reach_235958");
        eod_cnt  = 0;
        eod_tick = 0;
        for (int k = 1; k <= 3 * CLK_HZ; k++) begin
            step();
            eod_cnt  += end_of_day;
            eod_tick += (end_of_day & tick_1Hz);
            if (k == 2 * CLK_HZ) begin
                check("t2_midnight_hms", {hours, minutes, seconds}, {4'd12, 6'd0, 6'd0});
                check("t2_midnight_pm", am_or_pm, 0);
                check("t2_midnight_eod", end_of_day, 0);
            end
        end
        check("t2_eod_cycles", eod_cnt, CLK_HZ);
        check("t2_eod_tick_high", eod_tick, CLK_HZ / 2);

        // ---- 3: held minute button -----------------------------------
        do_reset();
        inc_minute = 1'b1;
        changes    = 0;
        prev_min   = minutes;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (minutes != prev_min) changes++;
            prev_min = minutes;
            if (k == 3) check("t3_min_c3", minutes, 0);
            if (k == 4) check("t3_min_c4", minutes, 1);
            if (k == 4) check("t3_sec_c4", seconds, 0);
        end
        check("t3_changes", changes, 1);
        check("t3_hours", hours, 12);
        inc_minute = 1'b0;
        repeat (4) step();

        // ---- 4: minute event coincident with sec_carry at 11:59:59 AM -
        do_reset();
        repeat (11) press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        wait_for(11 * 3600 + 59 * 60 + 59, (CLK_HZ - 4) % CLK_HZ, 400, "t4_reach_115959");
        inc_minute = 1'b1;
        repeat (4) step();
        check("t4_hms", {hours, minutes, seconds}, {4'd11, 6'd0, 6'd0});
        check("t4_pm", am_or_pm, 0);
        inc_minute = 1'b0;
        repeat (4) step();

        // ---- 5: table of presses from 11 AM ---------------------------
        do_reset();
        repeat (11) press(1'b1, 1'b0);
        check("t5_start", hours, 11);
        for (int i = 0; i < 15; i++) begin
            press(tbl[i].hr, tbl[i].mn);
            check("t5_hours", hours, tbl[i].exp_h);
            check("t5_minutes", minutes, tbl[i].exp_m);
            check("t5_pm", am_or_pm, tbl[i].exp_pm);
        end

        // ---- random presses and resets against the model -------------
        do_reset();
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 12);
            if (r == 12) begin
                repeat ($urandom_range(0, 3)) step();
                do_reset();
            end else begin
                inc_hour   = (r == 1 || r == 3 || r == 5);
                inc_minute = (r == 2 || r == 3 || r == 6);
                repeat ($urandom_range(1, 6)) step();
                inc_hour   = 1'b0;
                inc_minute = 1'b0;
                repeat ($urandom_range(1, 6)) step();
            end
        end

        // ---- 6: reset mid-second at 03:45:17 PM -----------------------
        do_reset();
        repeat (15) press(1'b1, 1'b0);
        repeat (45) press(1'b0, 1'b1);
        wait_for(15 * 3600 + 45 * 60 + 17, 2, 400, "t6_reach_154517");
        check("t6_before", {hours, minutes, seconds}, {4'd3, 6'd45, 6'd17});
        check("t6_before_pm", am_or_pm, 1);
        reset = 1'b0;
        step();
        check("t6_after", {hours, minutes, seconds}, {4'd12, 6'd0, 6'd0});
        check("t6_after_pm", am_or_pm, 0);
        check("t6_after_tick", tick_1Hz, 0);
        reset       = 1'b1;
        first_pulse = -1;
        for (int k = 1; k <= 3 * CLK_HZ && first_pulse < 0; k++) begin
            step();
            if (sec_pulse) first_pulse = k;
        end
        check("t6_first_pulse", first_pulse, CLK_HZ);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
